uart_rx_ctrl: RTL and testbench

Parametrised UART receive controller for the serial RX path. It folds the receive FSM, the edge and bit counters, the majority-vote sampler, the deserializer and the parity and stop checkers into one block. It supports a configurable data width, none/even/odd parity, one or two stop bits, and back-to-back frames. It sits between the synchronised `rx_in` line and the system-side byte consumer.

---
 rtl/uart_rx_pkg.sv | 24 ++
 rtl/uart_rx_ctrl_if.sv | 31 +++
 rtl/uart_rx_sampler.sv | 41 ++++
 rtl/uart_rx_ctrl.sv | 136 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_rx_pkg: shared types and helpers for the UART receive path
// Rev 1.0
// ------------------------------------------------------------------
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_rx_ctrl_if: serial line, frame configuration and byte output
// Rev 1.0
// ------------------------------------------------------------------
interface uart_rx_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
);
  logic                  rx_in;
  logic [PRESCALE_W-1:0] prescale;
  logic                  par_en;
  logic                  par_typ;
  logic                  two_stop;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stop_err;
  logic                  busy;

  modport master (
    input  rx_in, prescale, par_en, par_typ, two_stop,
    output p_data, data_valid, par_err, stop_err, busy
  );

  modport slave (
    output rx_in, prescale, par_en, par_typ, two_stop,
    input  p_data, data_valid, par_err, stop_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_rx_sampler: mid-bit triple sampling with majority vote
// Rev 1.0
// ------------------------------------------------------------------
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  bit_val,
  output logic                  decide
);

  logic [PRESCALE_W-1:0] half;
  logic                  samp_a;
  logic                  samp_b;

  assign half = prescale >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else begin
      if (edge_cnt == half - PRESCALE_W'(1)) samp_a <= rx_in;
      if (edge_cnt == half)                  samp_b <= rx_in;
    end
  end

  // Third vote is the live line in the decision cycle itself.
  assign decide  = (edge_cnt == half + PRESCALE_W'(1));
  assign bit_val = majority3(samp_a, samp_b, rx_in);

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_rx_ctrl: UART receive FSM, deserializer, parity/stop checking
// Rev 1.0
// ------------------------------------------------------------------
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input logic            CLK,
  input logic            RST,
  uart_rx_ctrl_if.master bus
);

  uart_rx_state_e        state;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] pre_l;
  logic [3:0]            bit_cnt;
  logic                  par_en_l;
  logic                  par_typ_l;
  logic                  two_stop_l;
  logic                  par_fail;
  logic                  stop_fail;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  bit_val;
  logic                  decide;
  logic                  bit_end;
  logic [3:0]            last_stop;
  logic                  stop_now;
  logic                  par_exp;

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .clk      (CLK),
    .rst      (RST),
    .rx_in    (bus.rx_in),
    .edge_cnt (edge_cnt),
    .prescale (pre_l),
    .bit_val  (bit_val),
    .decide   (decide)
  );

  // Bit index within the frame: 0 = start, 1..DATA_WIDTH = data, then parity/stops.
  assign bit_end   = (edge_cnt == pre_l - PRESCALE_W'(1));
  assign last_stop = 4'(DATA_WIDTH) + 4'd1 + {3'b000, par_en_l} + {3'b000, two_stop_l};
  assign stop_now  = stop_fail | ~bit_val;
  assign par_exp   = (^shreg) ^ (par_typ_l == PAR_ODD);
  assign bus.busy  = (state != ST_IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= ST_IDLE;
      edge_cnt       <= '0;
      bit_cnt        <= '0;
      pre_l          <= '0;
      par_en_l       <= 1'b0;
      par_typ_l      <= 1'b0;
      two_stop_l     <= 1'b0;
      par_fail       <= 1'b0;
      stop_fail      <= 1'b0;
      shreg          <= '0;
      bus.p_data     <= '0;
      bus.data_valid <= 1'b0;
      bus.par_err    <= 1'b0;
      bus.stop_err   <= 1'b0;
    end else begin
      bus.data_valid <= 1'b0;
      bus.par_err    <= 1'b0;
      bus.stop_err   <= 1'b0;

      if (state != ST_IDLE) begin
        if (bit_end) begin
          edge_cnt <= '0;
          bit_cnt  <= bit_cnt + 4'd1;
        end else begin
          edge_cnt <= edge_cnt + PRESCALE_W'(1);
        end
      end

      case (state)
        ST_IDLE: begin
          if (!bus.rx_in) begin
            state      <= ST_START;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            pre_l      <= bus.prescale;
            par_en_l   <= bus.par_en;
            par_typ_l  <= bus.par_typ;
            two_stop_l <= bus.two_stop;
            par_fail   <= 1'b0;
            stop_fail  <= 1'b0;
          end
        end
        ST_START: begin
          if (decide && bit_val) begin
            state <= ST_IDLE;
          end else if (bit_end) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (decide) shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
          if (bit_end && (bit_cnt == 4'(DATA_WIDTH))) begin
            state <= par_en_l ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (decide && (bit_val != par_exp)) par_fail <= 1'b1;
          if (bit_end) state <= ST_STOP;
        end
        ST_STOP: begin
          // Frame ends at the last stop decision so an immediate start bit is not missed.
          if (decide) begin
            if (bit_cnt == last_stop) begin
              state        <= ST_IDLE;
              bus.par_err  <= par_fail;
              bus.stop_err <= stop_now;
              if (!par_fail && !stop_now) begin
                bus.p_data     <= shreg;
                bus.data_valid <= 1'b1;
              end
            end else begin
              stop_fail <= stop_now;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_uart_rx_ctrl: directed frames against 8-bit and 7-bit receivers
// Rev 1.0
// ------------------------------------------------------------------
module tb_uart_rx_ctrl;
  import uart_rx_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en = 1'b0;
  logic       par_typ = PAR_EVEN;
  logic       two_stop = 1'b0;
  int         cyc = 0;
  int         n_assert = 0;
  int         n_fail = 0;

  int dv8_n = 0, pe8_n = 0, se8_n = 0, ovl_n = 0;
  int dv8_cyc = -1, pe8_cyc = -1, busy8_rise = -1, busy8_fall = -1;
  logic [7:0] dv8_data = 8'h00;
  logic busy8_q = 1'b0;
  int dv7_n = 0, pe7_n = 0, se7_n = 0, se7_cyc = -1;

  uart_rx_ctrl_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) if8 ();
  uart_rx_ctrl_if #(.DATA_WIDTH(7), .PRESCALE_W(6)) if7 ();

  assign if8.rx_in = rx;
  assign if8.prescale = prescale;
  assign if8.par_en = par_en;
  assign if8.par_typ = par_typ;
  assign if8.two_stop = two_stop;
  assign if7.rx_in = rx;
  assign if7.prescale = prescale;
  assign if7.par_en = par_en;
  assign if7.par_typ = par_typ;
  assign if7.two_stop = two_stop;

  uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut8 (.CLK(clk), .RST(rst), .bus(if8));
  uart_rx_ctrl #(.DATA_WIDTH(7), .PRESCALE_W(6)) dut7 (.CLK(clk), .RST(rst), .bus(if7));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder, sampled mid-cycle; cyc holds the index of the current cycle.
  always @(negedge clk) begin
    if (if8.data_valid) begin dv8_n++; dv8_cyc = cyc; dv8_data = if8.p_data; end
    if (if8.par_err) begin pe8_n++; pe8_cyc = cyc; end
    if (if8.stop_err) se8_n++;
    if (if8.data_valid && (if8.par_err || if8.stop_err)) ovl_n++;
    if (if7.data_valid && (if7.par_err || if7.stop_err)) ovl_n++;
    if (if8.busy && !busy8_q) busy8_rise = cyc;
    if (!if8.busy && busy8_q) busy8_fall = cyc;
    busy8_q = if8.busy;
    if (if7.data_valid) dv7_n++;
    if (if7.par_err) pe7_n++;
    if (if7.stop_err) begin se7_n++; se7_cyc = cyc; end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Starts in the current cycle (t0); each bit is held for p cycles.
  task automatic send_frame(input logic [8:0] data, input int nbits, input int p,
                            input logic pe, input logic pt, input logic ts,
                            input logic flip_par, input logic bad_stop2, output int t0);
    logic par;
    logic bits[$];
    par = pt ^ flip_par;
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      bits.push_back(data[i]);
      par ^= data[i];
    end
    if (pe) bits.push_back(par);
    bits.push_back(1'b1);
    if (ts) bits.push_back(~bad_stop2);
    t0 = cyc;
    foreach (bits[i]) begin
      rx = bits[i];
      wait_cycles(p);
    end
    rx = 1'b1;
  endtask

  task automatic set_cfg(input logic [5:0] p, input logic pe, input logic pt, input logic ts);
    prescale = p; par_en = pe; par_typ = pt; two_stop = ts;
    wait_cycles(2);
  endtask

  task automatic test_reset;
    rst = 1'b1; rx = 1'b1;
    wait_cycles(3);
    n_assert++; if (if8.p_data !== 8'h00) begin n_fail++; $display("FAIL reset_p_data8: got %h expected 00", if8.p_data); end
    n_assert++; if (if8.data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv8: got %b expected 0", if8.data_valid); end
    n_assert++; if (if8.par_err !== 1'b0) begin n_fail++; $display("FAIL reset_pe8: got %b expected 0", if8.par_err); end
    n_assert++; if (if8.stop_err !== 1'b0) begin n_fail++; $display("FAIL reset_se8: got %b expected 0", if8.stop_err); end
    n_assert++; if (if8.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy8: got %b expected 0", if8.busy); end
    n_assert++; if (if7.p_data !== 7'h00) begin n_fail++; $display("FAIL reset_p_data7: got %h expected 00", if7.p_data); end
    rst = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_8n1;
    int t0, d0, p0, s0;
    set_cfg(6'd8, 1'b0, PAR_EVEN, 1'b0);
    d0 = dv8_n; p0 = pe8_n; s0 = se8_n;
    send_frame(9'h0A5, 8, 8, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b0, t0);
    wait_cycles(10);
    n_assert++; if (dv8_n !== d0 + 1) begin n_fail++; $display("FAIL 8n1_dv_count: got %0d expected %0d", dv8_n, d0 + 1); end
    n_assert++; if (dv8_cyc !== t0 + 79) begin n_fail++; $display("FAIL 8n1_dv_cycle: got %0d expected %0d", dv8_cyc, t0 + 79); end
    n_assert++; if (dv8_data !== 8'hA5) begin n_fail++; $display("FAIL 8n1_data: got %h expected a5", dv8_data); end
    n_assert++; if (if8.p_data !== 8'hA5) begin n_fail++; $display("FAIL 8n1_p_data_hold: got %h expected a5", if8.p_data); end
    n_assert++; if ((pe8_n !== p0) || (se8_n !== s0)) begin n_fail++; $display("FAIL 8n1_no_err: got pe=%0d se=%0d expected pe=%0d se=%0d", pe8_n, se8_n, p0, s0); end
    n_assert++; if (busy8_rise !== t0 + 1) begin n_fail++; $display("FAIL 8n1_busy_rise: got %0d expected %0d", busy8_rise, t0 + 1); end
    n_assert++; if (busy8_fall !== t0 + 79) begin n_fail++; $display("FAIL 8n1_busy_fall: got %0d expected %0d", busy8_fall, t0 + 79); end
  endtask

  task automatic test_parity_err;
    int t0, d0, p0, s0;
    set_cfg(6'd16, 1'b1, PAR_EVEN, 1'b0);
    d0 = dv8_n; p0 = pe8_n; s0 = se8_n;
    send_frame(9'h03C, 8, 16, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b0, t0);
    wait_cycles(20);
    n_assert++; if (pe8_n !== p0 + 1) begin n_fail++; $display("FAIL par_err_count: got %0d expected %0d", pe8_n, p0 + 1); end
    n_assert++; if (pe8_cyc !== t0 + 171) begin n_fail++; $display("FAIL par_err_cycle: got %0d expected %0d", pe8_cyc, t0 + 171); end
    n_assert++; if ((dv8_n !== d0) || (se8_n !== s0)) begin n_fail++; $display("FAIL par_err_only: got dv=%0d se=%0d expected dv=%0d se=%0d", dv8_n, se8_n, d0, s0); end
    n_assert++; if (if8.p_data !== 8'hA5) begin n_fail++; $display("FAIL par_err_p_data: got %h expected a5", if8.p_data); end
  endtask

  task automatic test_glitch;
    int t0, t1, d0, p0, s0;
    set_cfg(6'd16, 1'b0, PAR_EVEN, 1'b0);
    d0 = dv8_n; p0 = pe8_n; s0 = se8_n;
    rx = 1'b0; t0 = cyc;
    wait_cycles(2);
    rx = 1'b1;
    wait_cycles(8);
    n_assert++; if (if8.busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_t10: got %b expected 1 at cycle %0d", if8.busy, cyc - t0); end
    wait_cycles(1);
    n_assert++; if (if8.busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle_t11: got %b expected 0 at cycle %0d", if8.busy, cyc - t0); end
    send_frame(9'h081, 8, 16, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b0, t1);
    wait_cycles(20);
    n_assert++; if (busy8_rise !== t1 + 1) begin n_fail++; $display("FAIL glitch_restart: got %0d expected %0d", busy8_rise, t1 + 1); end
    n_assert++; if (dv8_n !== d0 + 1) begin n_fail++; $display("FAIL glitch_dv_count: got %0d expected %0d", dv8_n, d0 + 1); end
    n_assert++; if (dv8_data !== 8'h81) begin n_fail++; $display("FAIL glitch_data: got %h expected 81", dv8_data); end
    n_assert++; if (dv8_cyc !== t1 + 155) begin n_fail++; $display("FAIL glitch_dv_cycle: got %0d expected %0d", dv8_cyc, t1 + 155); end
    n_assert++; if ((pe8_n !== p0) || (se8_n !== s0)) begin n_fail++; $display("FAIL glitch_no_err: got pe=%0d se=%0d expected pe=%0d se=%0d", pe8_n, se8_n, p0, s0); end
  endtask

  task automatic test_back_to_back;
    int ta, tb2, d0, c1;
    set_cfg(6'd8, 1'b0, PAR_EVEN, 1'b0);
    d0 = dv8_n;
    send_frame(9'h001, 8, 8, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b0, ta);
    n_assert++; if (dv8_data !== 8'h01) begin n_fail++; $display("FAIL b2b_data1: got %h expected 01", dv8_data); end
    n_assert++; if (dv8_cyc !== ta + 79) begin n_fail++; $display("FAIL b2b_cycle1: got %0d expected %0d", dv8_cyc, ta + 79); end
    c1 = dv8_cyc;
    send_frame(9'h0FE, 8, 8, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b0, tb2);
    wait_cycles(10);
    n_assert++; if (dv8_n !== d0 + 2) begin n_fail++; $display("FAIL b2b_dv_count: got %0d expected %0d", dv8_n, d0 + 2); end
    n_assert++; if (dv8_data !== 8'hFE) begin n_fail++; $display("FAIL b2b_data2: got %h expected fe", dv8_data); end
    n_assert++; if (dv8_cyc - c1 !== 80) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 80", dv8_cyc - c1); end
    n_assert++; if (ovl_n !== 0) begin n_fail++; $display("FAIL dv_err_overlap: got %0d expected 0", ovl_n); end
  endtask

  task automatic test_stop_err;
    int t0, d0, p0, s0;
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    set_cfg(6'd32, 1'b1, PAR_ODD, 1'b1);
    d0 = dv7_n; p0 = pe7_n; s0 = se7_n;
    send_frame(9'h055, 7, 32, 1'b1, PAR_ODD, 1'b1, 1'b0, 1'b1, t0);
    wait_cycles(20);
    n_assert++; if (se7_n !== s0 + 1) begin n_fail++; $display("FAIL stop_err_count: got %0d expected %0d", se7_n, s0 + 1); end
    n_assert++; if (se7_cyc !== t0 + 339) begin n_fail++; $display("FAIL stop_err_cycle: got %0d expected %0d", se7_cyc, t0 + 339); end
    n_assert++; if ((dv7_n !== d0) || (pe7_n !== p0)) begin n_fail++; $display("FAIL stop_err_only: got dv=%0d pe=%0d expected dv=%0d pe=%0d", dv7_n, pe7_n, d0, p0); end
    n_assert++; if (if7.p_data !== 7'h00) begin n_fail++; $display("FAIL stop_err_p_data: got %h expected 00", if7.p_data); end
    wait_cycles(500);
  endtask

  task automatic test_reset_midframe;
    int t0, d0, p0, s0;
    set_cfg(6'd8, 1'b0, PAR_EVEN, 1'b0);
    rx = 1'b0;
    wait_cycles(8);
    rx = 1'b1;
    wait_cycles(8);
    rx = 1'b0;
    wait_cycles(3);
    n_assert++; if (if8.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b expected 1", if8.busy); end
    d0 = dv8_n; p0 = pe8_n; s0 = se8_n;
    rst = 1'b1;
    wait_cycles(1);
    n_assert++; if (if8.p_data !== 8'h00) begin n_fail++; $display("FAIL midrst_p_data: got %h expected 00", if8.p_data); end
    n_assert++; if (if8.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", if8.busy); end
    n_assert++; if ({if8.data_valid, if8.par_err, if8.stop_err} !== 3'b000) begin n_fail++; $display("FAIL midrst_pulses: got %b expected 000", {if8.data_valid, if8.par_err, if8.stop_err}); end
    rst = 1'b0; rx = 1'b1;
    wait_cycles(30);
    n_assert++; if ((dv8_n !== d0) || (pe8_n !== p0) || (se8_n !== s0)) begin n_fail++; $display("FAIL midrst_no_pulse: got dv=%0d pe=%0d se=%0d expected %0d %0d %0d", dv8_n, pe8_n, se8_n, d0, p0, s0); end
    send_frame(9'h03A, 8, 8, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b0, t0);
    wait_cycles(10);
    n_assert++; if (dv8_n !== d0 + 1) begin n_fail++; $display("FAIL midrst_next_count: got %0d expected %0d", dv8_n, d0 + 1); end
    n_assert++; if (dv8_data !== 8'h3A) begin n_fail++; $display("FAIL midrst_next_data: got %h expected 3a", dv8_data); end
    n_assert++; if (dv8_cyc !== t0 + 79) begin n_fail++; $display("FAIL midrst_next_cycle: got %0d expected %0d", dv8_cyc, t0 + 79); end
  endtask

  initial begin
    test_reset;
    test_8n1;
    test_parity_err;
    test_glitch;
    test_back_to_back;
    test_stop_err;
    test_reset_midframe;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
